// File: rtl/rob_ctrl.sv
// Reorder-buffer allocation/retirement controller: all-or-nothing group dispatch, in-order retire.
// Optional squash support is compiled in with ROB_CTRL_FLUSH_EN (adds the i_flush port).
module rob_ctrl #(
    parameter int LEN    = 16,
    parameter int LBITS  = $clog2(LEN),
    parameter int RWIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_disp_valid,
    input  logic [2:0]       i_disp_count,
    output logic             o_disp_ready,
    output logic [LBITS-1:0] o_disp_tag,
    input  logic             i_cmpl_valid,
    input  logic [LBITS-1:0] i_cmpl_tag,
`ifdef ROB_CTRL_FLUSH_EN
    input  logic             i_flush,
`endif
    output logic [2:0]       o_retire_count,
    output logic [LBITS-1:0] o_retire_tag,
    output logic [LBITS:0]   o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [LBITS:0] LEN_C = (LBITS+1)'(LEN);

    logic [LBITS-1:0] head, tail;
    logic [LBITS:0]   count;
    logic [LEN-1:0]   alloc, done;

    logic             flush_now;
    logic             accept;
    logic [2:0]       acc_n, ret_n;
    logic [LBITS:0]   free_slots;
    logic [LEN-1:0]   set_mask, ret_mask, cmpl_mask;
    logic [LBITS-1:0] ret_idx;
    logic             run;

`ifdef ROB_CTRL_FLUSH_EN
    assign flush_now = i_flush;
`else
    assign flush_now = 1'b0;
`endif

    // Free space uses the current occupancy only; same-cycle retirements give no credit.
    always_comb begin
        free_slots = LEN_C - count;
        accept     = i_disp_valid && (i_disp_count != 3'd0) && !i_rst && !flush_now
                     && ((LBITS+1)'(i_disp_count) <= free_slots);
        acc_n      = accept ? i_disp_count : 3'd0;
        set_mask   = '0;
        for (int k = 0; k < 4; k++) begin
            if (accept && (3'(k) < i_disp_count))
                set_mask[head + LBITS'(k)] = 1'b1;
        end
    end

    // Retire the unbroken run of completed entries starting at the oldest one.
    always_comb begin
        ret_n    = 3'd0;
        ret_mask = '0;
        run      = 1'b1;
        ret_idx  = tail;
        for (int k = 0; k < RWIDTH; k++) begin
            ret_idx = tail + LBITS'(k);
            if (run && alloc[ret_idx] && done[ret_idx] && ((LBITS+1)'(k) < count)) begin
                ret_n             = ret_n + 3'd1;
                ret_mask[ret_idx] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
        if (flush_now) begin
            ret_n    = 3'd0;
            ret_mask = '0;
        end
    end

    always_comb begin
        cmpl_mask = '0;
        if (i_cmpl_valid && alloc[i_cmpl_tag] && !flush_now)
            cmpl_mask[i_cmpl_tag] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            alloc <= '0;
            done  <= '0;
        end else if (flush_now) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            alloc <= '0;
            done  <= '0;
        end else begin
            head  <= head + LBITS'(acc_n);
            tail  <= tail + LBITS'(ret_n);
            count <= count + (LBITS+1)'(acc_n) - (LBITS+1)'(ret_n);
            alloc <= (alloc & ~ret_mask) | set_mask;
            done  <= (done | cmpl_mask) & ~ret_mask & ~set_mask;
        end
    end

    assign o_disp_ready   = accept;
    assign o_disp_tag     = head;
    assign o_retire_count = ret_n;
    assign o_retire_tag   = tail;
    assign o_count        = count;
    assign o_full         = (count == LEN_C);
    assign o_empty        = (count == '0);

endmodule

// File: doc/rob_ctrl.md
# rob_ctrl

Allocation and retirement controller for the 16-entry reorder buffer. It sits between the 4-wide dispatch stage and the ROB storage array. It decides whether a dispatch group fits, hands out ROB tags and tracks per-entry completion. It also retires up to RWIDTH completed entries in program order each cycle and owns the authoritative head/tail/occupancy state that the ROB storage indexes with.

## Interface
- LEN, 16: ROB entries; power of two.
- LBITS, $clog2(LEN): tag/pointer width.
- RWIDTH, 2: max retirements per cycle (1..4).

- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_disp_valid  in  1  dispatch group present
- i_disp_count  in  3  instructions in group, 1..4 (0 treated as no request)
- o_disp_ready  out  1  group accepted this cycle (combinational)
- o_disp_tag  out  LBITS  tag of group slot 0 (= head); slot k gets head+k mod LEN
- i_cmpl_valid  in  1  execution unit reports completion
- i_cmpl_tag  in  LBITS  tag completing
- o_retire_count  out  3  entries retired at next edge (combinational), 0..RWIDTH
- o_retire_tag  out  LBITS  tag of oldest retiring entry (= tail)
- o_count  out  LBITS+1  occupancy, 0..LEN
- o_full, o_empty  out  1  count==LEN / count==0
- i_flush  in  1  squash all entries (only with ROB_CTRL_FLUSH_EN)

## Operation
- State: head, tail (LBITS, wrap mod LEN), count (LBITS+1), alloc[LEN], done[LEN].
- Dispatch: all-or-nothing. o_disp_ready = i_disp_valid && count!=0-independent check (LEN - count) >= i_disp_count && i_disp_count!=0. Free space uses current count; same-cycle retirements are not credited.
- On accept: set alloc for slots head..head+n-1 (mod LEN), clear their done bits, head += n.
- Completion: if i_cmpl_valid and alloc[i_cmpl_tag], set done. Completions to unallocated tags are ignored. Completion of an entry and its retirement cannot coincide, because retirement needs done already set.
- Retire: o_retire_count = the number of consecutive entries starting at tail with alloc&&done, capped at RWIDTH and at count. On edge: clear alloc/done for those slots, tail += retire_count.
- count_next = count + accepted_n - retire_count; never exceeds LEN and never underflows.
- Dispatch and retire in the same cycle are independent. Writes hit disjoint slots because an accepted group fits in free space.

## Timing
- Reset (async, i_rst high): head=tail=0, count=0, alloc=done=0. Outputs: o_count=0, o_empty=1, o_full=0, o_disp_ready=0, o_retire_count=0, o_disp_tag=0, o_retire_tag=0.
- o_disp_ready and o_retire_count are combinational from the current state and inputs. State updates at the following edge.
- A completion at edge N can first retire at edge N+1, so completion-to-retire latency is 1 cycle minimum.
- Tags are visible to dispatch in the accept cycle. Tag reuse is allowed in the cycle after retirement.
- Reset asserted mid-operation discards all state immediately. No retirement is reported for in-flight entries.

## Configuration
- ROB_CTRL_FLUSH_EN defined: i_flush port exists. i_flush high at an edge sets head=tail=0, count=0 and alloc=done=0. In a flush cycle, o_disp_ready=0 and o_retire_count=0, and completions that cycle are ignored. Flush has priority over all other events.
- Undefined: no i_flush port and no flush logic. The ROB empties only by retirement or reset.

## Test plan
- Reset, then dispatch 4,4,4,4 on consecutive cycles → tags 0,4,8,12. o_count 4,8,12,16. o_full=1. A 5th group of 1 gets o_disp_ready=0.
- Full ROB, complete tags 0..3 → o_retire_count 2 then 2 (RWIDTH=2), o_retire_tag 0 then 2. o_count 14 then 12. Then dispatch 4 is accepted with tag 0 (wrap).
- Complete tag 1 before tag 0 → o_retire_count stays 0. After tag 0 completes, the next cycle gives o_retire_count=2, o_retire_tag=0.
- count=13 and dispatch 4 with 2 retiring the same cycle → o_disp_ready=0 (no retire credit). The next cycle count=11 and dispatch 4 is accepted.
- Completion to unallocated tag 9 with count=0 → no state change. A later allocation of tag 9 starts not-done.
- With ROB_CTRL_FLUSH_EN: 10 entries, 3 done, i_flush plus dispatch 2 in the same cycle → o_disp_ready=0, o_retire_count=0. After the edge o_count=0 and o_empty=1, and the next dispatch gets tag 0.
